// File: rtl/stm1_frame_sequencer.sv
// STM-1 frame sequencer: merges SOH, POH and C4 byte streams into one registered,
// row-major 270x9 byte stream tagged with row, column, region and start-of-frame.
module stm1_frame_sequencer #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned STM1_COLS = 270,
   parameter int unsigned STM1_ROWS = 9,
   parameter int unsigned SOH_COLS  = 9,
   parameter int unsigned POH_COLS  = 1,
   parameter int unsigned FCNT_W    = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_en,
   input  logic [DATA_W-1:0] i_soh_data,
   input  logic              i_soh_valid,
   output logic              o_soh_ready,
   input  logic [DATA_W-1:0] i_poh_data,
   input  logic              i_poh_valid,
   output logic              o_poh_ready,
   input  logic [DATA_W-1:0] i_c4_data,
   input  logic              i_c4_valid,
   output logic              o_c4_ready,
   output logic [DATA_W-1:0] o_out_data,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [3:0]        o_out_row,
   output logic [8:0]        o_out_col,
   output logic [2:0]        o_out_region,
   output logic              o_out_sof,
   output logic              o_busy,
   output logic [FCNT_W-1:0] o_frame_cnt
);

   localparam logic [8:0] LAST_COL = 9'(STM1_COLS - 1);
   localparam logic [3:0] LAST_ROW = 4'(STM1_ROWS - 1);
   localparam logic [8:0] SOH_END  = 9'(SOH_COLS);
   localparam logic [8:0] POH_END  = 9'(SOH_COLS + POH_COLS);

   localparam logic [2:0] REG_RSOH = 3'd0;
   localparam logic [2:0] REG_PTR  = 3'd1;
   localparam logic [2:0] REG_MSOH = 3'd2;
   localparam logic [2:0] REG_POH  = 3'd3;
   localparam logic [2:0] REG_C4   = 3'd4;

   typedef enum logic [1:0] {StIdle, StRun, StStopping} state_t;

   state_t              r_state, w_state_next;
   logic [3:0]          r_row;
   logic [8:0]          r_col;
   logic [DATA_W-1:0]   r_out_data;
   logic                r_out_valid;
   logic [3:0]          r_out_row;
   logic [8:0]          r_out_col;
   logic [2:0]          r_out_region;
   logic                r_out_sof;
   logic [FCNT_W-1:0]   r_frame_cnt;

   logic [2:0]          w_region;
   logic                w_sel_valid;
   logic [DATA_W-1:0]   w_sel_data;
   logic                w_sel_soh, w_sel_poh, w_sel_c4;
   logic                w_load;
   logic                w_last_col, w_frame_end;

   // Region of the byte at the current (row, col) position.
   always_comb begin
      w_region = REG_C4;
      if (r_col < SOH_END) begin
         if (r_row <= 4'd2)      w_region = REG_RSOH;
         else if (r_row == 4'd3) w_region = REG_PTR;
         else                    w_region = REG_MSOH;
      end else if (r_col < POH_END) begin
         w_region = REG_POH;
      end
   end

   // Select the source stream owning the current region.
   always_comb begin
      w_sel_valid = 1'b0;
      w_sel_data  = '0;
      w_sel_soh   = 1'b0;
      w_sel_poh   = 1'b0;
      w_sel_c4    = 1'b0;
      unique case (w_region)
         REG_RSOH, REG_PTR, REG_MSOH: begin
            w_sel_soh   = 1'b1;
            w_sel_valid = i_soh_valid;
            w_sel_data  = i_soh_data;
         end
         REG_POH: begin
            w_sel_poh   = 1'b1;
            w_sel_valid = i_poh_valid;
            w_sel_data  = i_poh_data;
         end
         default: begin
            w_sel_c4    = 1'b1;
            w_sel_valid = i_c4_valid;
            w_sel_data  = i_c4_data;
         end
      endcase
   end

   assign w_load      = (r_state != StIdle) && w_sel_valid && (!r_out_valid || i_out_ready);
   assign w_last_col  = (r_col == LAST_COL);
   assign w_frame_end = w_last_col && (r_row == LAST_ROW);

   assign o_soh_ready = w_load & w_sel_soh;
   assign o_poh_ready = w_load & w_sel_poh;
   assign o_c4_ready  = w_load & w_sel_c4;

   // Run/stop control; a stop request only takes effect on the last byte of a frame.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:     if (i_en) w_state_next = StRun;
         StRun: begin
            if (!i_en) w_state_next = (w_load && w_frame_end) ? StIdle : StStopping;
         end
         StStopping: begin
            if (i_en)                         w_state_next = StRun;
            else if (w_load && w_frame_end)   w_state_next = StIdle;
         end
         default:    w_state_next = StIdle;
      endcase
   end

   // State register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= StIdle;
      else       r_state <= w_state_next;
   end

   // Row/column position and completed-frame count, advanced per loaded byte.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_row       <= '0;
         r_col       <= '0;
         r_frame_cnt <= '0;
      end else if (w_load) begin
         if (w_last_col) begin
            r_col <= '0;
            if (r_row == LAST_ROW) begin
               r_row       <= '0;
               r_frame_cnt <= r_frame_cnt + 1'b1;
            end else begin
               r_row <= r_row + 4'd1;
            end
         end else begin
            r_col <= r_col + 9'd1;
         end
      end
   end

   // Single-entry output register; holds while stalled downstream, empties when drained.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_out_data   <= '0;
         r_out_valid  <= 1'b0;
         r_out_row    <= '0;
         r_out_col    <= '0;
         r_out_region <= '0;
         r_out_sof    <= 1'b0;
      end else if (w_load) begin
         r_out_data   <= w_sel_data;
         r_out_valid  <= 1'b1;
         r_out_row    <= r_row;
         r_out_col    <= r_col;
         r_out_region <= w_region;
         r_out_sof    <= (r_row == 4'd0) && (r_col == 9'd0);
      end else if (i_out_ready) begin
         r_out_valid  <= 1'b0;
      end
   end

   assign o_out_data   = r_out_data;
   assign o_out_valid  = r_out_valid;
   assign o_out_row    = r_out_row;
   assign o_out_col    = r_out_col;
   assign o_out_region = r_out_region;
   assign o_out_sof    = r_out_sof;
   assign o_busy       = (r_state != StIdle);
   assign o_frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_stm1_frame_sequencer.sv
// Randomized bench for stm1_frame_sequencer against a frame-position reference model.
module tb_stm1_frame_sequencer;

   localparam int FRAME_BYTES = 270 * 9;

   logic        clk = 1'b0;
   logic        i_rst, i_en;
   logic [7:0]  i_soh_data, i_poh_data, i_c4_data;
   logic        i_soh_valid, i_poh_valid, i_c4_valid, i_out_ready;
   logic        o_soh_ready, o_poh_ready, o_c4_ready;
   logic [7:0]  o_out_data;
   logic        o_out_valid, o_out_sof, o_busy;
   logic [3:0]  o_out_row;
   logic [8:0]  o_out_col;
   logic [2:0]  o_out_region;
   logic [15:0] o_frame_cnt;
   logic [25:0] dut_out;

   always #5 clk = ~clk;

   assign dut_out = {o_out_valid, o_out_data, o_out_row, o_out_col, o_out_region, o_out_sof};

   stm1_frame_sequencer dut (
      .i_clk        (clk),
      .i_rst        (i_rst),
      .i_en         (i_en),
      .i_soh_data   (i_soh_data),
      .i_soh_valid  (i_soh_valid),
      .o_soh_ready  (o_soh_ready),
      .i_poh_data   (i_poh_data),
      .i_poh_valid  (i_poh_valid),
      .o_poh_ready  (o_poh_ready),
      .i_c4_data    (i_c4_data),
      .i_c4_valid   (i_c4_valid),
      .o_c4_ready   (o_c4_ready),
      .o_out_data   (o_out_data),
      .o_out_valid  (o_out_valid),
      .i_out_ready  (i_out_ready),
      .o_out_row    (o_out_row),
      .o_out_col    (o_out_col),
      .o_out_region (o_out_region),
      .o_out_sof    (o_out_sof),
      .o_busy       (o_busy),
      .o_frame_cnt  (o_frame_cnt)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: frame position, run flag, output register image, stream heads.
   bit          m_busy;
   int          m_k;
   logic [15:0] m_frames;
   logic [25:0] m_out;
   int          sc[3];
   int          cnt_rdy[3];
   int          ptr_bad;

   // Stimulus controls.
   bit g_en;
   int g_vmode;   // 0: all valid, 1: random valids
   int g_rmode;   // 0: ready high, 1: ready 1-in-3, 2: random ready
   bit g_c4_off;
   int cyc = 0;

   function automatic logic [7:0] gen_byte(input int s, input int n);
      return 8'((n * (2 * s + 3) + 37 * s + 1) & 255);
   endfunction

   function automatic int region_of(input int k);
      int r, c;
      r = k / 270;
      c = k % 270;
      if (c < 9) return (r <= 2) ? 0 : ((r == 3) ? 1 : 2);
      if (c == 9) return 3;
      return 4;
   endfunction

   function automatic int stream_of(input int reg_id);
      if (reg_id <= 2) return 0;
      if (reg_id == 3) return 1;
      return 2;
   endfunction

   task automatic cycle();
      bit [2:0]   v;
      bit         rdy, load, nb;
      int         rg, s;
      logic [7:0] d[3];
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 3; i++) begin
         v[i] = (g_vmode == 0) ? 1'b1 : (($urandom % 4) != 0);
         d[i] = gen_byte(i, sc[i]);
      end
      if (g_c4_off) v[2] = 1'b0;
      case (g_rmode)
         0:       rdy = 1'b1;
         1:       rdy = (cyc % 3 == 0);
         default: rdy = (($urandom % 5) != 0);
      endcase
      i_en        = g_en;
      i_soh_valid = v[0];
      i_poh_valid = v[1];
      i_c4_valid  = v[2];
      i_soh_data  = d[0];
      i_poh_data  = d[1];
      i_c4_data   = d[2];
      i_out_ready = rdy;
      rg   = region_of(m_k);
      s    = stream_of(rg);
      load = m_busy && v[s] && (!m_out[25] || rdy);
      #1;
      check_eq("ready", {o_c4_ready, o_poh_ready, o_soh_ready}, load ? (64'd1 << s) : 64'd0);
      check_eq("out", dut_out, m_out);
      check_eq("busy", o_busy, m_busy);
      check_eq("fcnt", o_frame_cnt, m_frames);
      cnt_rdy[0] += o_soh_ready;
      cnt_rdy[1] += o_poh_ready;
      cnt_rdy[2] += o_c4_ready;
      if (o_out_valid && o_out_region == 3'd1 && (o_out_row != 4'd3 || o_out_col > 9'd8))
         ptr_bad++;
      @(posedge clk);
      nb = m_busy;
      if (load) begin
         m_out = {1'b1, d[s], 4'(m_k / 270), 9'(m_k % 270), 3'(rg), (m_k == 0)};
         sc[s]++;
         if (m_k == FRAME_BYTES - 1) begin
            m_k = 0;
            m_frames++;
            if (!g_en) nb = 1'b0;
         end else begin
            m_k++;
         end
      end else if (rdy) begin
         m_out[25] = 1'b0;
      end
      if (!m_busy && g_en) nb = 1'b1;
      m_busy = nb;
   endtask

   task automatic do_reset();
      @(negedge clk);
      i_rst = 1'b1;
      i_en  = 1'b0;
      g_en  = 1'b0;
      #1;
      m_busy   = 1'b0;
      m_k      = 0;
      m_frames = '0;
      m_out    = '0;
      check_eq("rst_out", dut_out, m_out);
      check_eq("rst_rdy", {o_c4_ready, o_poh_ready, o_soh_ready}, 0);
      check_eq("rst_fcnt", o_frame_cnt, m_frames);
      check_eq("rst_busy", o_busy, 0);
      @(posedge clk);
      @(negedge clk);
      i_rst = 1'b0;
   endtask

   task automatic run_until_k(input int target, input int budget);
      int n = 0;
      while (m_k != target && n < budget) begin
         cycle();
         n++;
      end
      check_eq("reach_pos", m_k, target);
   endtask

   initial begin
      int sc0;
      i_rst = 1'b1; i_en = 1'b0; i_out_ready = 1'b0;
      i_soh_valid = 1'b0; i_poh_valid = 1'b0; i_c4_valid = 1'b0;
      i_soh_data = '0; i_poh_data = '0; i_c4_data = '0;
      g_en = 0; g_vmode = 0; g_rmode = 0; g_c4_off = 0;
      for (int i = 0; i < 3; i++) begin sc[i] = 0; cnt_rdy[i] = 0; end
      ptr_bad = 0;
      do_reset();

      // Full-rate first frame.
      g_en = 1;
      cycle();
      cycle();
      #1;
      check_eq("first_byte", dut_out, {1'b1, gen_byte(0, 0), 4'd0, 9'd0, 3'd0, 1'b1});
      while (m_frames == 0 && cyc < 3000) cycle();
      check_eq("soh_cnt", cnt_rdy[0], 81);
      check_eq("poh_cnt", cnt_rdy[1], 9);
      check_eq("c4_cnt", cnt_rdy[2], 2340);
      #1;
      check_eq("fcnt_one", o_frame_cnt, 1);

      // Random valids with 1-in-3 downstream ready.
      g_vmode = 1; g_rmode = 1;
      repeat (4000) cycle();

      // C4 stall at row 2, col 100.
      g_vmode = 0; g_rmode = 0;
      run_until_k(2 * 270 + 100, 3000);
      g_c4_off = 1;
      repeat (5) cycle();
      #1;
      check_eq("stall_gap", o_out_valid, 0);
      g_c4_off = 0;
      cycle();
      #1;
      check_eq("resume_col", {o_out_valid, o_out_row, o_out_col}, {1'b1, 4'd2, 9'd100});

      // Stop request mid-frame: frame completes, then idle.
      g_rmode = 2;
      run_until_k(4 * 270 + 50, 3000);
      g_en = 0;
      for (int n = 0; n < 4000 && m_busy; n++) cycle();
      #1;
      check_eq("stopped", {o_busy, o_out_row, o_out_col}, {1'b0, 4'd8, 9'd269});
      repeat (6) cycle();

      // Re-enable during the stopping phase: no idle cycle between frames.
      g_en = 1;
      run_until_k(1000, 4000);
      g_en = 0;
      run_until_k(2000, 4000);
      g_en = 1;
      run_until_k(10, 4000);
      #1;
      check_eq("no_gap_busy", o_busy, 1);

      // Reset mid-frame at row 6, col 200.
      g_rmode = 0;
      run_until_k(6 * 270 + 200, 4000);
      do_reset();
      sc0  = sc[0];
      g_en = 1;
      cycle();
      cycle();
      #1;
      check_eq("post_rst_byte", dut_out, {1'b1, gen_byte(0, sc0), 4'd0, 9'd0, 3'd0, 1'b1});
      check_eq("post_rst_fcnt", o_frame_cnt, 0);
      g_vmode = 1; g_rmode = 2;
      repeat (500) cycle();

      check_eq("ptr_place", ptr_bad, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
